// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU request port and a single-cycle
// data memory; does bounds/alignment checks and sub-word read-modify-write.
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // 33-bit so the upper bound cannot wrap
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr < BASE_ADDR)
                || ({1'b0, req_addr} > LIMIT);

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                state_d = RESP;
          else if (!req_we)           state_d = READ;
          else if (req_size == 2'b10) state_d = WRITE;
          else                        state_d = RMW_RD;
        end
      end
      READ:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    unique case (addr_q[1:0])
      2'd0: lane_b = ReadData[7:0];
      2'd1: lane_b = ReadData[15:8];
      2'd2: lane_b = ReadData[23:16];
      default: lane_b = ReadData[31:24];
    endcase
    lane_h = addr_q[1] ? ReadData[31:16] : ReadData[15:0];
    load_val = ReadData;
    if (size_q == 2'b00)
      load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
    else if (size_q == 2'b01)
      load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
  end

  // replace only the addressed lane of the word read back
  always_comb begin
    merge_val = ReadData;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            word_q  <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
          end
        end
        READ:   rdata_q <= load_val;
        RMW_RD: word_q  <= merge_val;
        default: ;
      endcase
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign MemRead  = !rst && !we_q
                  ? (state_q == READ)
                  : !rst && (state_q == RMW_RD);
  assign MemWrite = !rst && (state_q == WRITE);
  assign address  = {addr_q[31:2], 2'b00};
  assign WriteData = (state_q == WRITE) ? word_q : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 64-word behavioural memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .WriteData(WriteData),
    .ReadData(ReadData)
  );

  function automatic logic [5:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[7:2];
  endfunction

  assign ReadData = MemRead ? mem[widx(address)] : 32'h0;

  always @(posedge clk) begin
    if (MemWrite) mem[widx(address)] <= WriteData;
    if (MemRead) rd_cnt <= rd_cnt + 1;
    if (MemWrite) wr_cnt <= wr_cnt + 1;
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input int stall);
    logic [31:0] first;
    bit found;
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    resp_ready = (stall == 0);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      r_lat++;
      if (resp_valid) found = 1;
    end
    if (!found) check("timeout", 32'd0, 32'd1);
    r_data = resp_rdata;
    r_err = resp_err;
    first = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, first);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
    check("sw_wr_cnt", wr_cnt, 32'd1);
    check("sw_rd_cnt", rd_cnt, 32'd0);
    check("sw_err", {31'd0, r_err}, 32'd0);
    check("sw_mem", mem[0], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 0);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_err", {31'd0, r_err}, 32'd0);
    check("lw_lat", r_lat, 32'd2);

    mem[0] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 32'd1026, 32'hFFFFFF5A, 0);
    check("sb_rd_cnt", rd_cnt, 32'd1);
    check("sb_wr_cnt", wr_cnt, 32'd1);
    check("sb_mem", mem[0], 32'h115A3344);
    mem[0] = 32'h12803456;
    do_req(1'b0, 2'b00, 1'b0, 32'd1026, 32'h0, 0);
    check("lb_signed", r_data, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'd1026, 32'h0, 0);
    check("lb_unsigned", r_data, 32'h00000080);
    do_req(1'b0, 2'b00, 1'b1, 32'd1027, 32'h0, 0);
    check("lb_lane3", r_data, 32'h00000012);

    mem[1] = 32'h80017FFF;
    do_req(1'b1, 2'b01, 1'b0, 32'd1028, 32'h0000BEEF, 0);
    check("sh_mem", mem[1], 32'h8001BEEF);
    do_req(1'b0, 2'b01, 1'b0, 32'd1030, 32'h0, 0);
    check("lh_hi_signed", r_data, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'd1030, 32'h0, 0);
    check("lh_hi_unsigned", r_data, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'd1028, 32'h0, 0);
    check("lh_lo_signed", r_data, 32'hFFFFBEEF);

    do_req(1'b0, 2'b10, 1'b0, 32'd1020, 32'h0, 0);
    check("err_below", {r_data[30:0], r_err}, 32'd1);
    check("err_below_mem", rd_cnt + wr_cnt, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'd1280, 32'h0, 0);
    check("err_above", {r_data[30:0], r_err}, 32'd1);
    check("err_above_mem", rd_cnt + wr_cnt, 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'd1025, 32'h0, 0);
    check("err_half", {r_data[30:0], r_err}, 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'd1024, 32'h0, 0);
    check("err_size", {r_data[30:0], r_err}, 32'd1);
    check("err_size_mem", rd_cnt + wr_cnt, 32'd0);
    check("err_size_keep", mem[0], 32'h12803456);
    mem[63] = 32'hA5A5A5A5;
    do_req(1'b0, 2'b10, 1'b0, 32'd1276, 32'h0, 0);
    check("last_word_err", {31'd0, r_err}, 32'd0);
    check("last_word", r_data, 32'hA5A5A5A5);

    do_req(1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, 5);
    check("stall_data", r_data, 32'h8001BEEF);
    check("one_hot", both_cnt, 32'd0);

    mem[5] = 32'h01020304;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_addr = 32'd1044;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wr_state", {31'd0, MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_gate_wr", {31'd0, MemWrite}, 32'd0);
    check("rst_gate_rdy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rst_mem", mem[5], 32'h01020304);
    check("rst_resp", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1 check("rst_ready_after", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024, first byte address of data memory window SHALL be set by this parameter.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words in the window SHALL be set by this parameter.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU access request present.
REQ-006 req_ready  output  1  controller accepts request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  CPU consumes response.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  access rejected.
REQ-016 MemRead  output  1  read strobe to data memory.
REQ-017 MemWrite  output  1  write strobe to data memory (memory writes on rising edge).
REQ-018 address  output  32  word-aligned byte address to memory (req_addr with [1:0] cleared).
REQ-019 WriteData  output  32  word to memory.
REQ-020 ReadData  input  32  memory read word, valid combinationally while MemRead=1, Z otherwise.

Function
REQ-021 FSM states SHALL be IDLE, READ, RMW_RD, WRITE, RESP; MemRead/MemWrite SHALL decode from registered state only.
REQ-022 req_ready SHALL be 1 exactly in IDLE with rst=0; request accepted on edge with req_valid&&req_ready; addr, we, size, unsigned, wdata latched then.
REQ-023 Error = size 11, OR half with addr[0]=1, OR word with addr[1:0]!=0, OR addr<BASE_ADDR, OR addr>BASE_ADDR+4*DEPTH_WORDS-1 (32-bit compare, no wrap).
REQ-024 Accept with error: IDLE->RESP, resp_err=1, resp_rdata=0, no MemRead/MemWrite asserted for that access.
REQ-025 Load: IDLE->READ (MemRead=1, word captured at end of cycle)->RESP; resp_valid first high 2 cycles after accept edge.
REQ-026 Load extraction little-endian: byte lane addr[1:0], half lane addr[1]; extend per req_unsigned; word passed unchanged.
REQ-027 Word store: IDLE->WRITE (MemWrite=1, WriteData=wdata)->RESP.
REQ-028 Byte/half store: IDLE->RMW_RD (MemRead=1, capture word)->WRITE (MemWrite=1, captured word with addressed lane replaced by wdata[7:0]/[15:0])->RESP; other lanes unchanged.
REQ-029 RESP: resp_valid=1, outputs stable until edge with resp_ready=1, then ->IDLE; no new request accepted in the same cycle (one idle cycle min between responses).
REQ-030 MemRead and MemWrite SHALL never be 1 simultaneously; outside READ/RMW_RD MemRead=0, outside WRITE MemWrite=0.
REQ-031 address/WriteData SHALL hold latched values in all non-IDLE states; WriteData=0 outside WRITE.

Reset
REQ-032 rst=1 at an edge: state->IDLE, resp_valid=0, resp_err=0, resp_rdata=0, latched registers cleared.
REQ-033 While rst=1: req_ready=0, MemRead=0, MemWrite=0 (gated combinationally), so an in-flight store in WRITE SHALL NOT reach memory.
REQ-034 Pending response at reset SHALL be discarded; first accept possible in cycle after rst deasserts.

Verification
REQ-035 Word store 0xDEADBEEF @1024, then word load @1024 -> MemWrite one cycle, resp_rdata=0xDEADBEEF, resp_err=0, latency 2 cycles.
REQ-036 Byte store 0x5A @1026 over 0x11223344 -> RMW_RD then WRITE, memory word 0x115A3344; signed byte load @1026 of 0x80 -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-037 Word load @1020, @1280, half @1025, size 11 -> resp_err=1, resp_rdata=0, MemRead/MemWrite never asserted; @1276 word accepted without error.
REQ-038 resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata stable, req_ready=0 throughout.
REQ-039 rst asserted while in WRITE -> MemWrite=0 that cycle, memory word unchanged, resp_valid=0, req_ready=1 cycle after rst deasserts.
